// File: rtl/fir_pkg.sv
// Shared FIR display-path types and constants: converter FSM states, blank digit code,
// and the default converter geometry also used by the 7-segment digit multiplexer.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    // Matches the 7-segment decoder's blank code
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam int unsigned BCD_WIDTH  = 27;
    localparam int unsigned BCD_DIGITS = 9;

endpackage

// File: rtl/bcd_shift_converter_if.sv
// Handshake/result bundle between a binary source and bcd_shift_converter.
// master drives start/data; slave (the converter) drives status and result.
interface bcd_shift_converter_if
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH  = BCD_WIDTH,
    parameter int unsigned DIGITS = BCD_DIGITS
);

    logic                  start;
    logic [WIDTH-1:0]      data;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic                  neg;

    modport master (
        output start, data,
        input  busy, done, bcd, ovf, neg
    );

    modport slave (
        input  start, data,
        output busy, done, bcd, ovf, neg
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_shift_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_SIGNED_EN to treat data as two's complement and report the sign on neg.
module bcd_shift_converter
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH  = BCD_WIDTH,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    bcd_shift_converter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_work;
    logic               r_ovf_sticky;
    logic               r_neg_work;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_neg;

    logic [WIDTH-1:0]   w_mag;
    logic               w_is_neg;
    logic [BCD_W-1:0]   w_adj;

`ifdef BCD_SIGNED_EN
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
    assign w_is_neg = bus.data[WIDTH-1];
    assign w_mag    = w_is_neg ? -bus.data : bus.data;
`else
    assign w_is_neg = 1'b0;
    assign w_mag    = bus.data;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_work[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_work       <= '0;
            r_ovf_sticky <= 1'b0;
            r_neg_work   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
            r_neg        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift      <= w_mag;
                        r_work       <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_neg_work   <= w_is_neg;
                        r_cnt        <= CNT_W'(WIDTH);
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work  <= {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
                    r_shift <= r_shift << 1;
                    // A set top bit after correction is a carry into a digit we do not have
                    if (w_adj[BCD_W-1]) begin
                        r_ovf_sticky <= 1'b1;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_bcd   <= r_ovf_sticky ? {DIGITS{BCD_BLANK}} : r_work;
                    r_ovf   <= r_ovf_sticky;
                    r_neg   <= r_neg_work;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;
    assign bus.neg  = r_neg;

endmodule

// File: tb/tb_bcd_shift_converter.sv
// Directed bench for bcd_shift_converter: default 27-bit instance, a 30-bit instance
// for overflow, and an 8-bit instance exercised when BCD_SIGNED_EN is defined.
module tb_bcd_shift_converter;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_shift_converter_if #(.WIDTH(27), .DIGITS(9)) ifa ();
    bcd_shift_converter_if #(.WIDTH(30), .DIGITS(9)) ifb ();
    bcd_shift_converter_if #(.WIDTH(8),  .DIGITS(3)) ifc ();

    bcd_shift_converter #(.WIDTH(27), .DIGITS(9)) u_dut_a (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (ifa)
    );

    bcd_shift_converter #(.WIDTH(30), .DIGITS(9)) u_dut_b (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (ifb)
    );

    bcd_shift_converter #(.WIDTH(8), .DIGITS(3)) u_dut_c (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (ifc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each start task returns 1 time unit after the accepting edge (edge 0)
    task automatic start_a(input logic [26:0] d);
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.data  = d;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
    endtask

    task automatic start_b(input logic [29:0] d);
        @(negedge clk);
        ifb.start = 1'b1;
        ifb.data  = d;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
    endtask

    task automatic start_c(input logic [7:0] d);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.data  = d;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    // lat = edges until done seen (0 if bound expires); busy_bad counts cycles busy was low
    task automatic wait_done_a(output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done) begin
                lat = i;
                break;
            end
            if (!ifa.busy) busy_bad++;
        end
    endtask

    task automatic wait_done_b(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (ifb.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_done_c(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (ifc.done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int bb;
        int dones;

        ifa.start = 1'b0; ifa.data = '0;
        ifb.start = 1'b0; ifb.data = '0;
        ifc.start = 1'b0; ifc.data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_done", 64'(ifa.done), 64'd0);
        check("rst_bcd",  64'(ifa.bcd),  64'd0);
        check("rst_ovf",  64'(ifa.ovf),  64'd0);
        check("rst_neg",  64'(ifa.neg),  64'd0);
        reset = 1'b0;

        // data = 0: latency 28, busy for cycles 1..28 only
        start_a(27'd0);
        check("zero_busy_edge0", 64'(ifa.busy), 64'd1);
        wait_done_a(lat, bb);
        check("zero_latency",   64'(lat), 64'd28);
        check("zero_busy_gap",  64'(bb), 64'd0);
        check("zero_busy_done", 64'(ifa.busy), 64'd0);
        check("zero_bcd",       64'(ifa.bcd), 64'd0);
        check("zero_ovf",       64'(ifa.ovf), 64'd0);
        @(posedge clk);
        #1;
        check("zero_done_1cyc", 64'(ifa.done), 64'd0);

        // 255 with start held every cycle: one done, then an immediate second conversion
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.data  = 27'd255;
        @(posedge clk);
        #1;
        dones = 0;
        for (int i = 1; i <= 28; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done) dones++;
        end
        check("held_dones",   64'(dones), 64'd1);
        check("held_done28",  64'(ifa.done), 64'd1);
        check("held_bcd",     64'(ifa.bcd), 64'h000000255);
        @(posedge clk);
        #1;
        check("held_restart_busy", 64'(ifa.busy), 64'd1);
        check("held_restart_done", 64'(ifa.done), 64'd0);
        ifa.start = 1'b0;
        wait_done_a(lat, bb);
        check("held2_latency", 64'(lat), 64'd28);
        check("held2_bcd",     64'(ifa.bcd), 64'h000000255);

`ifndef BCD_SIGNED_EN
        // Full-scale value; bcd must hold the old result mid-conversion
        start_a(27'd134217727);
        repeat (5) @(posedge clk);
        #1;
        check("max_bcd_hold", 64'(ifa.bcd), 64'h000000255);
        wait_done_a(lat, bb);
        check("max_latency", 64'(lat + 5), 64'd28);
        check("max_bcd",     64'(ifa.bcd), 64'h134217727);
        check("max_ovf",     64'(ifa.ovf), 64'd0);
        check("max_neg",     64'(ifa.neg), 64'd0);
`endif

        // Reset sampled on the edge of shift 10
        start_a(27'd12345);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(ifa.busy), 64'd0);
        check("abort_done", 64'(ifa.done), 64'd0);
        check("abort_bcd",  64'(ifa.bcd),  64'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

`ifndef BCD_SIGNED_EN
        // 30-bit instance: 10-digit value overflows 9 digits
        start_b(30'd1000000000);
        wait_done_b(lat);
        check("ovf_latency", 64'(lat), 64'd31);
        check("ovf_flag",    64'(ifb.ovf), 64'd1);
        check("ovf_blank",   64'(ifb.bcd), 64'hFFFFFFFFF);
        start_b(30'd999999999);
        wait_done_b(lat);
        check("nines_latency", 64'(lat), 64'd31);
        check("nines_ovf",     64'(ifb.ovf), 64'd0);
        check("nines_bcd",     64'(ifb.bcd), 64'h999999999);
`else
        start_c(8'hFF);
        wait_done_c(lat);
        check("s_ff_latency", 64'(lat), 64'd9);
        check("s_ff_neg",     64'(ifc.neg), 64'd1);
        check("s_ff_bcd",     64'(ifc.bcd), 64'h001);
        start_c(8'h80);
        wait_done_c(lat);
        check("s_80_neg", 64'(ifc.neg), 64'd1);
        check("s_80_bcd", 64'(ifc.bcd), 64'h128);
        check("s_80_ovf", 64'(ifc.ovf), 64'd0);
        start_c(8'h7F);
        wait_done_c(lat);
        check("s_7f_neg", 64'(ifc.neg), 64'd0);
        check("s_7f_bcd", 64'(ifc.bcd), 64'h127);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
